mem_arbiter: RTL and testbench

Shares the single data-memory port (the `d_cache` backing memory) between the instruction-fetch stage and the execute stage's load/store path. It uses a three-state FSM with registered outputs. Data accesses have fixed priority, and a starvation counter guarantees fetch progress. A `flush` input (the execute stage's `clr`) cancels delivery of an in-flight fetch response. It sits between `if`/`exe` and the memory model.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_prio.sv | 42 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding, counter sizing.
// No logic; imported by mem_arbiter and mem_arb_prio.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OWN_DATA  = 1'b0;
  localparam logic OWN_FETCH = 1'b1;

  function automatic int starve_cnt_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision (combinational, valid only while the FSM is idle) and saturating
// starvation counter; data wins contention until fetch has waited STARVE_MAX grants.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = starve_cnt_w(STARVE_MAX)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_idle,
  input  logic i_d_req,
  input  logic i_i_req,
  output logic o_grant,
  output logic o_owner
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;

  always_comb begin
    w_full  = (r_cnt == MAX_C);
    o_grant = i_idle & (i_d_req | i_i_req);
    o_owner = (i_i_req & (~i_d_req | w_full)) ? OWN_FETCH : OWN_DATA;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (o_grant) begin
      if (o_owner == OWN_FETCH) begin
        r_cnt <= '0;
      end else if (i_i_req && !w_full) begin
        // Only a data grant that actually made fetch wait counts.
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store: IDLE -> MEM (held until m_ack) -> RESP.
// Request-to-valid is 2 cycles minimum; requests wait while the port is busy (sampled only in IDLE).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ready,
  output logic              o_d_valid,
  output logic [DATA_W-1:0] o_d_rdata,
  input  logic              i_i_req,
  input  logic [ADDR_W-1:0] i_i_addr,
  output logic              o_i_ready,
  output logic              o_i_valid,
  output logic [DATA_W-1:0] o_i_rdata,
  input  logic              i_flush,
  output logic              o_m_req,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic              i_m_ack,
  input  logic [DATA_W-1:0] i_m_rdata
);

  state_t            r_state, w_state_nxt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_killed;
  logic              r_m_req;
  logic              r_d_ready, r_i_ready;
  logic              r_d_valid, r_i_valid;
  logic [DATA_W-1:0] r_d_rdata, r_i_rdata;
  logic              w_grant, w_owner;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_idle  (r_state == S_IDLE),
    .i_d_req (i_d_req),
    .i_i_req (i_i_req),
    .o_grant (w_grant),
    .o_owner (w_owner)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_MEM;
      S_MEM:   if (i_m_ack) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner   <= OWN_DATA;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_killed  <= 1'b0;
      r_m_req   <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_ready <= 1'b0;
      r_d_valid <= 1'b0;
      r_i_valid <= 1'b0;
      r_d_rdata <= '0;
      r_i_rdata <= '0;
    end else begin
      r_d_ready <= 1'b0;
      r_i_ready <= 1'b0;
      r_d_valid <= 1'b0;
      r_i_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner   <= w_owner;
            r_m_req   <= 1'b1;
            r_d_ready <= (w_owner == OWN_DATA);
            r_i_ready <= (w_owner == OWN_FETCH);
            r_addr    <= (w_owner == OWN_FETCH) ? i_i_addr : i_d_addr;
            r_we      <= (w_owner == OWN_DATA) & i_d_we;
            r_wdata   <= (w_owner == OWN_FETCH) ? '0 : i_d_wdata;
          end
        end
        S_MEM: begin
          if (i_flush && r_owner == OWN_FETCH) r_killed <= 1'b1;
          if (i_m_ack) begin
            r_m_req <= 1'b0;
            if (r_owner == OWN_DATA) begin
              r_d_rdata <= r_we ? '0 : i_m_rdata;
              r_d_valid <= 1'b1;
            end else begin
              // Word is captured even when killed; only the valid is withheld.
              r_i_rdata <= i_m_rdata;
              r_i_valid <= ~r_killed & ~i_flush;
            end
          end
        end
        S_RESP:  r_killed <= 1'b0;
        default: r_killed <= 1'b0;
      endcase
    end
  end

  assign o_d_ready = r_d_ready;
  assign o_i_ready = r_i_ready;
  assign o_d_valid = r_d_valid;
  // A flush arriving in the response cycle itself still cancels delivery.
  assign o_i_valid = r_i_valid & ~i_flush;
  assign o_d_rdata = r_d_rdata;
  assign o_i_rdata = r_i_rdata;
  assign o_m_req   = r_m_req;
  assign o_m_we    = r_we;
  assign o_m_addr  = r_addr;
  assign o_m_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load, store, contention order, flush cases, async reset.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_we, i_req, flush, m_ack;
  logic [31:0] d_addr, d_wdata, i_addr, m_rdata;
  logic        d_ready, d_valid, i_ready, i_valid, m_req, m_we;
  logic [31:0] d_rdata, i_rdata, m_addr, m_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_d_req   (d_req),
    .i_d_we    (d_we),
    .i_d_addr  (d_addr),
    .i_d_wdata (d_wdata),
    .o_d_ready (d_ready),
    .o_d_valid (d_valid),
    .o_d_rdata (d_rdata),
    .i_i_req   (i_req),
    .i_i_addr  (i_addr),
    .o_i_ready (i_ready),
    .o_i_valid (i_valid),
    .o_i_rdata (i_rdata),
    .i_flush   (flush),
    .o_m_req   (m_req),
    .o_m_we    (m_we),
    .o_m_addr  (m_addr),
    .o_m_wdata (m_wdata),
    .i_m_ack   (m_ack),
    .i_m_rdata (m_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  logic [9:0] f_pat;
  logic [2:0] exp_cnt;

  initial begin
    rst = 1'b1; d_req = 0; d_we = 0; i_req = 0; flush = 0; m_ack = 0;
    d_addr = 0; d_wdata = 0; i_addr = 0; m_rdata = 0;
    #3;
    chk("rst_m_req", m_req, 0);
    chk("rst_ready", {d_ready, i_ready}, 0);
    chk("rst_valid", {d_valid, i_valid}, 0);
    chk("rst_rdata", {d_rdata, i_rdata}, 0);
    chk("rst_state", dut.r_state, S_IDLE);
    step; step;
    rst = 1'b0;

    // Single load, ack in cycle 4 -> valid in cycle 5
    step; d_req = 1; d_addr = 32'h100; d_we = 0;
    step; d_req = 0; settle;
    chk("ld_d_ready", d_ready, 1);
    chk("ld_m_req", m_req, 1);
    chk("ld_m_addr", m_addr, 32'h100);
    chk("ld_m_we", m_we, 0);
    chk("ld_i_ready", i_ready, 0);
    step; settle;
    chk("ld_ready_pulse", d_ready, 0);
    chk("ld_m_req_c2", m_req, 1);
    step;
    step; m_ack = 1; m_rdata = 32'hDEADBEEF; settle;
    chk("ld_no_early_valid", d_valid, 0);
    step; m_ack = 0; settle;
    chk("ld_d_valid", d_valid, 1);
    chk("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("ld_m_req_drop", m_req, 0);
    chk("ld_no_i", {i_valid, i_ready}, 0);
    step; settle;
    chk("ld_valid_pulse", d_valid, 0);
    chk("ld_rdata_hold", d_rdata, 32'hDEADBEEF);

    // Store
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
    step; d_req = 0; d_we = 0; d_wdata = 0; settle;
    chk("st_d_ready", d_ready, 1);
    chk("st_m_we", m_we, 1);
    chk("st_m_wdata", m_wdata, 32'h12345678);
    chk("st_m_addr", m_addr, 32'h40);
    step; m_ack = 1; m_rdata = 32'hAAAA5555; settle;
    chk("st_wdata_held", m_wdata, 32'h12345678);
    chk("st_we_held", m_we, 1);
    step; m_ack = 0; settle;
    chk("st_d_valid", d_valid, 1);
    chk("st_d_rdata", d_rdata, 0);
    chk("st_m_req_drop", m_req, 0);

    // Contention: D,D,D,D,F repeated
    step; d_req = 1; i_req = 1; d_addr = 32'h300; i_addr = 32'h400;
    f_pat = 10'b10000_10000;
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step; m_ack = 1; m_rdata = 32'h1000 + i; settle;
      if (f_pat[i]) exp_cnt = 0;
      else          exp_cnt = exp_cnt + 1;
      chk($sformatf("cont_i_ready_%0d", i), i_ready, f_pat[i]);
      chk($sformatf("cont_d_ready_%0d", i), d_ready, !f_pat[i]);
      chk($sformatf("cont_cnt_%0d", i), dut.u_prio.r_cnt, exp_cnt);
      step; m_ack = 0; settle;
      chk($sformatf("cont_valid_%0d", i), {d_valid, i_valid}, {!f_pat[i], f_pat[i]});
      step;
      if (i == 9) begin d_req = 0; i_req = 0; end
      settle;
    end

    // Flush in MEM, one cycle before ack
    step; i_req = 1; i_addr = 32'h200;
    step; i_req = 0; settle;
    chk("fl_i_ready", i_ready, 1);
    chk("fl_m_addr", m_addr, 32'h200);
    step; flush = 1;
    step; flush = 0; m_ack = 1; m_rdata = 32'hCAFEF00D; settle;
    chk("fl_m_req_held", m_req, 1);
    step; m_ack = 0; settle;
    chk("fl_i_valid", i_valid, 0);
    chk("fl_i_rdata", i_rdata, 32'hCAFEF00D);
    step; i_req = 1; i_addr = 32'h204; settle;
    chk("fl_i_valid_idle", i_valid, 0);
    step; i_req = 0; m_ack = 1; m_rdata = 32'h11112222; settle;
    chk("fl_next_ready", i_ready, 1);
    chk("fl_next_addr", m_addr, 32'h204);
    step; m_ack = 0; settle;
    chk("fl_next_valid", i_valid, 1);
    chk("fl_next_rdata", i_rdata, 32'h11112222);

    // Flush exactly in RESP
    step; i_req = 1; i_addr = 32'h208;
    step; i_req = 0; m_ack = 1; m_rdata = 32'h33334444;
    step; m_ack = 0; flush = 1; settle;
    chk("flr_i_valid", i_valid, 0);
    chk("flr_i_rdata", i_rdata, 32'h33334444);
    step; flush = 0; settle;
    chk("flr_i_valid_after", i_valid, 0);

    // Flush has no effect on a data transaction
    step; d_req = 1; d_addr = 32'h600; d_we = 0;
    step; d_req = 0; flush = 1; m_ack = 1; m_rdata = 32'h5A5A5A5A;
    step; m_ack = 0; settle;
    chk("fld_d_valid", d_valid, 1);
    chk("fld_d_rdata", d_rdata, 32'h5A5A5A5A);
    step; flush = 0;

    // Async reset while in MEM
    step; d_req = 1; i_req = 1; d_addr = 32'h500;
    step; d_req = 0; i_req = 0; settle;
    chk("rm_m_req", m_req, 1);
    chk("rm_cnt_pre", dut.u_prio.r_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("rm_m_req_low", m_req, 0);
    chk("rm_ready_low", {d_ready, i_ready}, 0);
    chk("rm_valid_low", {d_valid, i_valid}, 0);
    step; rst = 1'b0; m_ack = 1; settle;
    chk("rm_state", dut.r_state, S_IDLE);
    chk("rm_cnt", dut.u_prio.r_cnt, 0);
    step; m_ack = 0; settle;
    chk("rm_no_valid", {d_valid, i_valid, m_req}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
